// File: rtl/clutter_map_upd_ctrl_if.sv
// Signal bundle between clutter_map_upd_ctrl and its x(n) stream source, map RAM and recur_oper.
// master is the controller side, slave is the stream / RAM / datapath side.
interface clutter_map_upd_ctrl_if #(
    parameter int AW = 12
) ();
    logic          s_vld;
    logic          s_rdy;
    logic [15:0]   s_dat;

    logic          map_rd_en;
    logic [AW-1:0] map_rd_addr;
    logic [15:0]   map_rd_dat;

    logic [15:0]   recur_coeff;
    logic          recur_rd_vld;
    logic [15:0]   recur_din0;
    logic [15:0]   recur_din2;
    logic          recur_valid;
    logic [15:0]   recur_dat;

    logic          map_wr_en;
    logic [AW-1:0] map_wr_addr;
    logic [15:0]   map_wr_dat;

    modport master (
        input  s_vld, s_dat, map_rd_dat, recur_valid, recur_dat,
        output s_rdy, map_rd_en, map_rd_addr, recur_coeff, recur_rd_vld,
               recur_din0, recur_din2, map_wr_en, map_wr_addr, map_wr_dat
    );

    modport slave (
        output s_vld, s_dat, map_rd_dat, recur_valid, recur_dat,
        input  s_rdy, map_rd_en, map_rd_addr, recur_coeff, recur_rd_vld,
               recur_din0, recur_din2, map_wr_en, map_wr_addr, map_wr_dat
    );
endinterface

// File: rtl/clutter_map_upd_ctrl.sv
// Frame sequencer for the clutter-map update y(n)=k*x(n)+(1-k)*y(n-1): reads y(n-1), feeds recur_oper, writes y(n).
// Optional drain watchdog (output err_wdog) is enabled by defining CLUT_UPD_WDOG_EN.
module clutter_map_upd_ctrl #(
    parameter int NUM_CELLS = 4096,
    parameter int AW        = 12,
    parameter int RD_LAT    = 2,
    parameter int RECUR_LAT = 6
`ifdef CLUT_UPD_WDOG_EN
    ,
    parameter int WDOG_CYC  = 64
`endif
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [15:0]           cfg_coeff,
    input  logic                  cfg_init,
    input  logic                  frame_start,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_ovl,
`ifdef CLUT_UPD_WDOG_EN
    output logic                  err_wdog,
`endif
    clutter_map_upd_ctrl_if.master bus
);

    localparam int              CW       = AW + 1;
    localparam int              TOT      = RD_LAT + RECUR_LAT;
    localparam logic [CW-1:0]   NCELL    = CW'(NUM_CELLS);
    localparam logic [CW-1:0]   NCELL_M1 = CW'(NUM_CELLS - 1);
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [15:0]     K_MAX    = 16'd1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [15:0] clamp_coeff(input logic [15:0] k);
        if (k > K_MAX) begin
            return K_MAX;
        end else begin
            return k;
        end
    endfunction

    state_t          state_r;
    logic [CW-1:0]   rd_cnt_r;
    logic [CW-1:0]   wr_cnt_r;
    logic [15:0]     coeff_r;
    logic            seed_r;
    logic            frm_seed_r;
    logic            s_rdy_r;
    logic            busy_r;
    logic            frame_done_r;
    logic            err_ovl_r;

    logic [TOT-1:0]  dly_vld_r;
    logic [15:0]     dly_dat_r [TOT];

    logic            map_wr_en_r;
    logic [AW-1:0]   map_wr_addr_r;
    logic [15:0]     map_wr_dat_r;

    logic            xfer_s;
    logic            start_acc_s;
    logic            wr_src_vld_s;
    logic [15:0]     wr_src_dat_s;
    logic            wr_go_s;
    logic            recur_vld_s;
    logic [15:0]     din2_s;

`ifdef CLUT_UPD_WDOG_EN
    localparam int            WW       = $clog2(WDOG_CYC) + 1;
    localparam logic [WW-1:0] WDOG_LIM = WW'(WDOG_CYC - 1);
    localparam logic [WW-1:0] WD_ONE   = {{(WW-1){1'b0}}, 1'b1};
    logic [WW-1:0]   wdog_cnt_r;
    logic            err_wdog_r;
    assign err_wdog = err_wdog_r;
`endif

    // Handshake qualification and selection of the write source (seed bypass vs. recur_oper result)
    always_comb begin
        xfer_s      = bus.s_vld & s_rdy_r;
        start_acc_s = frame_start & (state_r == ST_IDLE);
        if (frm_seed_r) begin
            wr_src_vld_s = dly_vld_r[TOT-1];
            wr_src_dat_s = dly_dat_r[TOT-1];
        end else begin
            wr_src_vld_s = bus.recur_valid;
            wr_src_dat_s = bus.recur_dat;
        end
        if (((state_r == ST_RUN) || (state_r == ST_DRAIN)) && (wr_cnt_r < NCELL)) begin
            wr_go_s = wr_src_vld_s;
        end else begin
            wr_go_s = 1'b0;
        end
        recur_vld_s = dly_vld_r[RD_LAT-1] & ~frm_seed_r;
        if (recur_vld_s) begin
            din2_s = bus.map_rd_dat;
        end else begin
            din2_s = 16'd0;
        end
    end

    // Frame FSM: read counter, coefficient latch, seed bookkeeping and status pulses
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r      <= ST_IDLE;
            rd_cnt_r     <= '0;
            coeff_r      <= 16'd0;
            seed_r       <= 1'b1;
            frm_seed_r   <= 1'b0;
            s_rdy_r      <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            err_ovl_r    <= 1'b0;
`ifdef CLUT_UPD_WDOG_EN
            wdog_cnt_r   <= '0;
            err_wdog_r   <= 1'b0;
`endif
        end else begin
            frame_done_r <= 1'b0;
            err_ovl_r    <= frame_start & (state_r != ST_IDLE);
`ifdef CLUT_UPD_WDOG_EN
            err_wdog_r   <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_r    <= ST_RUN;
                        busy_r     <= 1'b1;
                        s_rdy_r    <= 1'b1;
                        coeff_r    <= clamp_coeff(cfg_coeff);
                        rd_cnt_r   <= '0;
                        frm_seed_r <= seed_r | cfg_init;
                        seed_r     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (xfer_s) begin
                        rd_cnt_r <= rd_cnt_r + CNT_ONE;
                        if (rd_cnt_r == NCELL_M1) begin
                            s_rdy_r <= 1'b0;
                            state_r <= ST_DRAIN;
                        end
                    end
`ifdef CLUT_UPD_WDOG_EN
                    wdog_cnt_r <= '0;
`endif
                end
                ST_DRAIN: begin
                    if (wr_cnt_r == NCELL) begin
                        state_r      <= ST_DONE;
                        busy_r       <= 1'b0;
                        frame_done_r <= 1'b1;
                    end
`ifdef CLUT_UPD_WDOG_EN
                    else if (wr_src_vld_s) begin
                        wdog_cnt_r <= '0;
                    end else if (wdog_cnt_r == WDOG_LIM) begin
                        // Stuck datapath: abandon the frame and force the next one to reseed the map
                        state_r      <= ST_DONE;
                        busy_r       <= 1'b0;
                        frame_done_r <= 1'b1;
                        err_wdog_r   <= 1'b1;
                        seed_r       <= 1'b1;
                    end else begin
                        wdog_cnt_r <= wdog_cnt_r + WD_ONE;
                    end
`endif
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    s_rdy_r <= 1'b0;
                end
            endcase
        end
    end

    // x(n) delay line (read-latency alignment plus seed bypass) and the map write port
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dly_vld_r     <= '0;
            for (int i = 0; i < TOT; i++) begin
                dly_dat_r[i] <= 16'd0;
            end
            wr_cnt_r      <= '0;
            map_wr_en_r   <= 1'b0;
            map_wr_addr_r <= '0;
            map_wr_dat_r  <= 16'd0;
        end else begin
            dly_vld_r    <= {dly_vld_r[TOT-2:0], xfer_s};
            dly_dat_r[0] <= bus.s_dat;
            for (int i = 1; i < TOT; i++) begin
                dly_dat_r[i] <= dly_dat_r[i-1];
            end
            map_wr_en_r <= wr_go_s;
            if (start_acc_s) begin
                wr_cnt_r <= '0;
            end else if (wr_go_s) begin
                wr_cnt_r <= wr_cnt_r + CNT_ONE;
            end
            if (wr_go_s) begin
                map_wr_addr_r <= wr_cnt_r[AW-1:0];
                map_wr_dat_r  <= wr_src_dat_s;
            end
        end
    end

    assign busy             = busy_r;
    assign frame_done       = frame_done_r;
    assign err_ovl          = err_ovl_r;
    assign bus.s_rdy        = s_rdy_r;
    assign bus.map_rd_en    = xfer_s;
    assign bus.map_rd_addr  = rd_cnt_r[AW-1:0];
    assign bus.recur_coeff  = coeff_r;
    assign bus.recur_rd_vld = recur_vld_s;
    assign bus.recur_din0   = dly_dat_r[RD_LAT-1];
    assign bus.recur_din2   = din2_s;
    assign bus.map_wr_en    = map_wr_en_r;
    assign bus.map_wr_addr  = map_wr_addr_r;
    assign bus.map_wr_dat   = map_wr_dat_r;

endmodule

// File: tb/tb_clutter_map_upd_ctrl.sv
// Scoreboard bench for clutter_map_upd_ctrl with a 16-cell map, a RAM model and a recur_oper model.
module tb_clutter_map_upd_ctrl;
    localparam int NC  = 16;
    localparam int AW  = 4;
    localparam int LAT = 9;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [15:0] cfg_coeff;
    logic        cfg_init;
    logic        frame_start;
    logic        busy, frame_done, err_ovl;
`ifdef CLUT_UPD_WDOG_EN
    logic        err_wdog;
    int          wdog_cnt = 0;
`endif

    clutter_map_upd_ctrl_if #(.AW(AW)) bif ();

    clutter_map_upd_ctrl #(.NUM_CELLS(NC), .AW(AW)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .cfg_coeff   (cfg_coeff),
        .cfg_init    (cfg_init),
        .frame_start (frame_start),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_ovl     (err_ovl),
`ifdef CLUT_UPD_WDOG_EN
        .err_wdog    (err_wdog),
`endif
        .bus         (bif)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct { int addr; int dat; } wr_exp_t;
    typedef struct { int x; int y; int k; } rd_exp_t;

    wr_exp_t wq[$];
    rd_exp_t rq[$];
    int      st_q[$];
    int      shadow [NC];
    int      err_cnt = 0, chk_cnt = 0;
    int      cyc = 0, done_cnt = 0, ovl_cnt = 0, rdvld_cnt = 0;
    bit      seed_pend = 1'b1;
    bit      withhold = 1'b0;

    task automatic check_val(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Map RAM model, read latency 2
    logic [15:0] mem [NC];
    logic [15:0] rd1_r, rd2_r;
    always @(posedge sys_clk) begin
        if (bif.map_wr_en) mem[bif.map_wr_addr] <= bif.map_wr_dat;
        rd1_r <= mem[bif.map_rd_addr];
        rd2_r <= rd1_r;
    end
    assign bif.map_rd_dat = rd2_r;

    // recur_oper model, latency 6
    logic [5:0]  rv_q;
    logic [15:0] rd_q [6];
    always @(posedge sys_clk) begin
        if (sys_rst) begin
            rv_q <= '0;
        end else begin
            rv_q <= {rv_q[4:0], bif.recur_rd_vld};
        end
        rd_q[0] <= 16'((int'(bif.recur_coeff) * int'(bif.recur_din0)
                       + (1000 - int'(bif.recur_coeff)) * int'(bif.recur_din2)) / 1000);
        for (int i = 1; i < 6; i++) rd_q[i] <= rd_q[i-1];
    end
    assign bif.recur_valid = rv_q[5] & ~withhold;
    assign bif.recur_dat   = rd_q[5];

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboards on datapath-input and map-write events
    wr_exp_t we;
    rd_exp_t re_m;
    always @(negedge sys_clk) begin
        if (frame_done) done_cnt++;
        if (err_ovl) ovl_cnt++;
`ifdef CLUT_UPD_WDOG_EN
        if (err_wdog) wdog_cnt++;
`endif
        if (bif.recur_rd_vld) begin
            rdvld_cnt++;
            if (rq.size() == 0) begin
                check_val("rd_vld_extra", 1, 0);
            end else begin
                re_m = rq.pop_front();
                check_val("din0", int'(bif.recur_din0), re_m.x);
                check_val("din2", int'(bif.recur_din2), re_m.y);
                check_val("coeff", int'(bif.recur_coeff), re_m.k);
            end
        end
        if (bif.map_wr_en) begin
            if (wq.size() == 0) begin
                check_val("wr_extra", 1, 0);
            end else begin
                we = wq.pop_front();
                check_val("wr_addr", int'(bif.map_wr_addr), we.addr);
                check_val("wr_dat", int'(bif.map_wr_dat), we.dat);
            end
            if (st_q.size() > 0) check_val("wr_lat", cyc - st_q.pop_front(), LAT);
        end
    end

    task automatic send_cell(input int x, output bit ok);
        bit rdy;
        bif.s_vld = 1'b1;
        bif.s_dat = 16'(x);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge sys_clk);
            rdy = bif.s_rdy;
            if (rdy) st_q.push_back(cyc);
            @(posedge sys_clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        bif.s_vld = 1'b0;
    endtask

    task automatic run_frame(input int k, input bit init, input int xbase, input int xstep,
                             input bit stall, input int ovl_idx, input bit no_wr);
        bit seed_now, ok, got_done;
        int kc, x, y, d0, o0;
        wr_exp_t w;
        rd_exp_t r;
        seed_now  = seed_pend | init;
        seed_pend = 1'b0;
        kc = (k > 1000) ? 1000 : k;
        d0 = done_cnt;
        o0 = ovl_cnt;
        cfg_coeff   = 16'(k);
        cfg_init    = init;
        frame_start = 1'b1;
        @(posedge sys_clk);
        #1;
        frame_start = 1'b0;
        cfg_init    = 1'b0;
        check_val("busy_run", int'(busy), 1);
        for (int i = 0; i < NC; i++) begin
            x = xbase + i * xstep;
            if (seed_now) begin
                y = x;
            end else begin
                y = (kc * x + (1000 - kc) * shadow[i]) / 1000;
                r.x = x; r.y = shadow[i]; r.k = kc;
                rq.push_back(r);
            end
            if (!no_wr) begin
                w.addr = i; w.dat = y;
                wq.push_back(w);
                shadow[i] = y;
            end
            if (stall && (i % 2 == 1)) begin
                repeat (2) @(posedge sys_clk);
                #1;
            end
            if (i == ovl_idx) frame_start = 1'b1;
            send_cell(x, ok);
            frame_start = 1'b0;
            check_val("xfer_ok", int'(ok), 1);
        end
        got_done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge sys_clk);
            if (frame_done) begin
                got_done = 1'b1;
                break;
            end
        end
        check_val("done_seen", int'(got_done), 1);
        repeat (3) @(negedge sys_clk);
        check_val("done_once", done_cnt - d0, 1);
        check_val("ovl_pulses", ovl_cnt - o0, (ovl_idx >= 0) ? 1 : 0);
        check_val("busy_idle", int'(busy), 0);
        check_val("wr_left", wq.size(), 0);
        check_val("rd_left", rq.size(), 0);
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int rv0;
        bit ok;
        rd_exp_t r;
        sys_rst = 1'b1; cfg_coeff = 16'd0; cfg_init = 1'b0; frame_start = 1'b0;
        bif.s_vld = 1'b0; bif.s_dat = 16'd0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(frame_done), 0);
        check_val("rst_ovl", int'(err_ovl), 0);
        check_val("rst_s_rdy", int'(bif.s_rdy), 0);
        check_val("rst_rd_en", int'(bif.map_rd_en), 0);
        check_val("rst_wr_en", int'(bif.map_wr_en), 0);
        check_val("rst_coeff", int'(bif.recur_coeff), 0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;

        // T1: first frame after reset seeds the map, datapath untouched
        rv0 = rdvld_cnt;
        run_frame(300, 1'b0, 0, 10, 1'b0, -1, 1'b0);
        check_val("t1_no_rd_vld", rdvld_cnt - rv0, 0);

        // T2: cfg_init reseeds with 400, then k=250 with x=800 gives 500
        run_frame(250, 1'b1, 400, 0, 1'b0, -1, 1'b0);
        run_frame(250, 1'b0, 800, 0, 1'b0, -1, 1'b0);
        check_val("t2_mem3", int'(mem[3]), 500);
        check_val("t2_coeff", int'(bif.recur_coeff), 250);

        // T3: coefficient above 1000 is clamped
        run_frame(1500, 1'b0, 1000, 5, 1'b0, -1, 1'b0);
        check_val("t3_coeff", int'(bif.recur_coeff), 1000);

        // T4: gaps in s_vld
        run_frame(500, 1'b0, 2000, 3, 1'b1, -1, 1'b0);

        // T5a: frame_start while busy is flagged and ignored
        run_frame(100, 1'b0, 60, 7, 1'b0, 4, 1'b0);

        // T5b: reset in the middle of RUN
        cfg_coeff = 16'd600;
        frame_start = 1'b1;
        @(posedge sys_clk);
        #1;
        frame_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            r.x = 900 + i; r.y = shadow[i]; r.k = 600;
            rq.push_back(r);
            send_cell(900 + i, ok);
        end
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        rq.delete(); wq.delete(); st_q.delete();
        @(negedge sys_clk);
        check_val("mid_rst_busy", int'(busy), 0);
        check_val("mid_rst_s_rdy", int'(bif.s_rdy), 0);
        check_val("mid_rst_rd_vld", int'(bif.recur_rd_vld), 0);
        check_val("mid_rst_wr_en", int'(bif.map_wr_en), 0);
        check_val("mid_rst_coeff", int'(bif.recur_coeff), 0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        seed_pend = 1'b1;
        repeat (20) @(posedge sys_clk);
        #1;
        rv0 = rdvld_cnt;
        run_frame(700, 1'b0, 3, 7, 1'b0, -1, 1'b0);
        check_val("t5_reseed_no_rd_vld", rdvld_cnt - rv0, 0);

`ifdef CLUT_UPD_WDOG_EN
        // T6: datapath never answers, watchdog closes the frame and forces a reseed
        begin
            int w0;
            w0 = wdog_cnt;
            withhold = 1'b1;
            run_frame(400, 1'b0, 50, 1, 1'b0, -1, 1'b1);
            withhold = 1'b0;
            st_q.delete();
            check_val("t6_wdog_once", wdog_cnt - w0, 1);
            seed_pend = 1'b1;
            repeat (10) @(posedge sys_clk);
            #1;
            rv0 = rdvld_cnt;
            run_frame(400, 1'b0, 11, 2, 1'b0, -1, 1'b0);
            check_val("t6_reseed_no_rd_vld", rdvld_cnt - rv0, 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: cycle %0d reached without completion", cyc);
        $fatal(1);
    end

endmodule
